// File: rtl/gcm_pkg.sv
// Shared definitions for the AES-GCM datapath.
// Block/word geometry and the keep-to-byte-mask helper.
package gcm_pkg;

    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;
    localparam int SLOT_W          = $clog2(WORDS_PER_BLOCK);
    localparam int KEEP_W          = WORD_W / 8;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [SLOT_W-1:0]  slot_t;
    typedef logic [KEEP_W-1:0]  keep_t;

    // keep[KEEP_W-1] governs the most significant byte of the word
    function automatic word_t keep_to_mask(input keep_t keep);
        word_t m;
        m = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            m[8*b +: 8] = {8{keep[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gcm_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers.
// Storage is not reset; the output is forced to zero when empty.
module gcm_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [WIDTH-1:0]         o_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_level = r_wptr - r_rptr;
    assign o_data  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/gcm_rx_packer.sv
// Packs a 32-bit word stream big-endian into 128-bit blocks and
// queues them for the encryptor's receive side.
module gcm_rx_packer
    import gcm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inValid,
    input  logic [WORD_W-1:0]      inData,
    input  logic [KEEP_W-1:0]      inKeep,
    input  logic                   inLast,
    output logic                   inReady,
    output logic                   rxEmpty,
    output logic [BLOCK_W-1:0]     rxData,
    input  logic                   rxPop,
    output logic [$clog2(DEPTH):0] level
);

    localparam slot_t LAST_SLOT = slot_t'(WORDS_PER_BLOCK - 1);

    slot_t  r_slot;
    block_t r_acc;

    word_t  w_word;
    block_t w_block;
    logic   w_last_slot;
    logic   w_commit_pending;
    logic   w_accept;
    logic   w_commit;
    logic   w_full;

    assign w_word = inLast ? (inData & keep_to_mask(inKeep)) : inData;

    // Unfilled slots in r_acc are already zero, so early commits pad
    always_comb begin
        w_block = r_acc;
        unique case (r_slot)
            2'd0: w_block[127:96] = w_word;
            2'd1: w_block[95:64]  = w_word;
            2'd2: w_block[63:32]  = w_word;
            2'd3: w_block[31:0]   = w_word;
        endcase
    end

    assign w_last_slot      = (r_slot == LAST_SLOT);
    assign w_commit_pending = w_last_slot || (inValid && inLast);
    assign inReady          = !(w_commit_pending && w_full);
    assign w_accept         = inValid && inReady;
    assign w_commit         = w_accept && (w_last_slot || inLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
            r_acc  <= '0;
        end else if (w_commit) begin
            r_slot <= '0;
            r_acc  <= '0;
        end else if (w_accept) begin
            r_slot <= r_slot + 1'b1;
            r_acc  <= w_block;
        end
    end

    gcm_sync_fifo #(
        .WIDTH (BLOCK_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_commit),
        .i_data  (w_block),
        .i_pop   (rxPop),
        .o_full  (w_full),
        .o_empty (rxEmpty),
        .o_level (level),
        .o_data  (rxData)
    );

endmodule

// File: tb/tb_gcm_rx_packer.sv
// Scoreboard bench for gcm_rx_packer: expected blocks are queued as
// words are driven and compared as blocks are popped.
module tb_gcm_rx_packer;

    localparam int DEPTH = 4;

    logic         clk;
    logic         rst;
    logic         inValid;
    logic [31:0]  inData;
    logic [3:0]   inKeep;
    logic         inLast;
    logic         inReady;
    logic         rxEmpty;
    logic [127:0] rxData;
    logic         rxPop;
    logic [2:0]   level;

    int checks   = 0;
    int failures = 0;
    logic [127:0] sbq[$];

    gcm_rx_packer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .inValid (inValid),
        .inData  (inData),
        .inKeep  (inKeep),
        .inLast  (inLast),
        .inReady (inReady),
        .rxEmpty (rxEmpty),
        .rxData  (rxData),
        .rxPop   (rxPop),
        .level   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] model(input logic [127:0] w, input int n,
                                           input logic last, input logic [3:0] keep);
        logic [127:0] blk;
        logic [31:0]  wd;
        blk = '0;
        for (int k = 0; k < n; k++) begin
            wd = w[127-32*k -: 32];
            if (last && k == n - 1) begin
                for (int b = 0; b < 4; b++)
                    if (!keep[b]) wd[8*b +: 8] = 8'h00;
            end
            blk[127-32*k -: 32] = wd;
        end
        return blk;
    endfunction

    task automatic send(input logic [31:0] d, input logic last, input logic [3:0] keep);
        bit done = 0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            inValid = 1'b1; inData = d; inLast = last; inKeep = keep;
            #1;
            if (inReady) begin
                @(posedge clk);
                done = 1;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL send_timeout word=%h accepted=0 required=1", d);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        inValid = 1'b0; inLast = 1'b0; inKeep = 4'h0; inData = '0;
    endtask

    task automatic send_block(input logic [127:0] w, input int n,
                              input logic last, input logic [3:0] keep);
        sbq.push_back(model(w, n, last, keep));
        for (int k = 0; k < n; k++)
            send(w[127-32*k -: 32], (k == n - 1) ? last : 1'b0, keep);
    endtask

    task automatic pop_block(output logic [127:0] d, output logic e);
        @(negedge clk);
        inValid = 1'b0; inLast = 1'b0;
        d = rxData; e = rxEmpty;
        rxPop = 1'b1;
        @(posedge clk);
        #1 rxPop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rxEmpty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", rxEmpty); end
        checks++;
        if (rxData !== 128'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", rxData); end
        checks++;
        if (level !== 3'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
        checks++;
        if (inReady !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", inReady); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_block();
        logic [127:0] d;
        logic e;
        send_block(128'hcafebabe_facedbad_decaf888_00000000, 4, 1'b0, 4'hf);
        idle();
        checks++;
        if (rxEmpty !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", rxEmpty); end
        checks++;
        if (level !== 3'd1) begin failures++; $display("FAIL full_level got=%0d exp=1", level); end
        checks++;
        if (rxData !== 128'hcafebabe_facedbad_decaf888_00000000) begin
            failures++; $display("FAIL full_data got=%h exp=cafebabefacedbaddecaf88800000000", rxData);
        end
        pop_block(d, e);
        checks++;
        if (d !== sbq[0]) begin failures++; $display("FAIL full_pop got=%h exp=%h", d, sbq[0]); end
        void'(sbq.pop_front());
    endtask

    task automatic test_partial_keep();
        logic [127:0] d;
        logic e;
        send_block({32'hd9313225, 32'hf88406e5, 64'h0}, 2, 1'b1, 4'b1100);
        idle();
        checks++;
        if (rxData !== 128'hd9313225_f8840000_00000000_00000000) begin
            failures++; $display("FAIL partial_data got=%h exp=d9313225f88400000000000000000000", rxData);
        end
        pop_block(d, e);
        void'(sbq.pop_front());
        send_block({32'h12345678, 96'h0}, 1, 1'b1, 4'b1111);
        idle();
        checks++;
        if (rxData !== 128'h12345678_00000000_00000000_00000000) begin
            failures++; $display("FAIL partial_slot0 got=%h exp=%h", rxData, sbq[0]);
        end
        pop_block(d, e);
        void'(sbq.pop_front());
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        logic e;
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        for (int b = 0; b < DEPTH; b++)
            send_block({$urandom, $urandom, $urandom, $urandom}, 4, 1'b0, 4'hf);
        idle();
        checks++;
        if (level !== 3'd4) begin failures++; $display("FAIL bp_fill_level got=%0d exp=4", level); end
        sbq.push_back(w);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            inValid = 1'b1; inData = w[127-32*k -: 32]; inLast = 1'b0; inKeep = 4'h0;
            #1;
            checks++;
            if (inReady !== 1'b1) begin failures++; $display("FAIL bp_slot%0d_ready got=%b exp=1", k, inReady); end
            @(posedge clk);
        end
        @(negedge clk);
        inValid = 1'b1; inData = w[31:0];
        #1;
        checks++;
        if (inReady !== 1'b0) begin failures++; $display("FAIL bp_stall_ready got=%b exp=0", inReady); end
        @(negedge clk);
        rxPop = 1'b1;
        d = rxData;
        #1;
        checks++;
        if (inReady !== 1'b0) begin failures++; $display("FAIL bp_pop_ready got=%b exp=0", inReady); end
        checks++;
        if (d !== sbq[0]) begin failures++; $display("FAIL bp_head got=%h exp=%h", d, sbq[0]); end
        void'(sbq.pop_front());
        @(negedge clk);
        rxPop = 1'b0;
        #1;
        checks++;
        if (inReady !== 1'b1) begin failures++; $display("FAIL bp_after_pop_ready got=%b exp=1", inReady); end
        checks++;
        if (level !== 3'd3) begin failures++; $display("FAIL bp_after_pop_level got=%0d exp=3", level); end
        @(posedge clk);
        idle();
        checks++;
        if (level !== 3'd4) begin failures++; $display("FAIL bp_refill_level got=%0d exp=4", level); end
        for (int k = 0; k < 20 && sbq.size() > 0; k++) begin
            pop_block(d, e);
            checks++;
            if (d !== sbq[0]) begin failures++; $display("FAIL bp_drain%0d got=%h exp=%h", k, d, sbq[0]); end
            void'(sbq.pop_front());
        end
    endtask

    task automatic test_wrap();
        logic [127:0] d;
        logic e;
        int popped = 0;
        @(negedge clk);
        rxPop = 1'b1;
        @(negedge clk);
        rxPop = 1'b0;
        checks++;
        if (level !== 3'd0 || rxData !== 128'h0 || rxEmpty !== 1'b1) begin
            failures++;
            $display("FAIL underflow got level=%0d data=%h empty=%b exp 0/0/1", level, rxData, rxEmpty);
        end
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 2)
                send_block({$urandom, $urandom, $urandom, $urandom}, 3, 1'b1, 4'($urandom));
            else
                send_block({$urandom, $urandom, $urandom, $urandom}, 4, 1'b0, 4'hf);
            if (i >= 1) begin
                pop_block(d, e);
                popped++;
                checks++;
                if (e !== 1'b0 || d !== sbq[0]) begin
                    failures++; $display("FAIL wrap_pop%0d got=%h empty=%b exp=%h", i, d, e, sbq[0]);
                end
                void'(sbq.pop_front());
            end
        end
        idle();
        for (int k = 0; k < 20 && sbq.size() > 0; k++) begin
            pop_block(d, e);
            popped++;
            checks++;
            if (d !== sbq[0]) begin failures++; $display("FAIL wrap_drain%0d got=%h exp=%h", k, d, sbq[0]); end
            void'(sbq.pop_front());
        end
        @(negedge clk);
        checks++;
        if (popped != 10 || rxEmpty !== 1'b1) begin
            failures++; $display("FAIL wrap_count got=%0d empty=%b exp=10 empty=1", popped, rxEmpty);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d;
        logic e;
        send(32'h11111111, 1'b0, 4'hf);
        send(32'h22222222, 1'b0, 4'hf);
        send(32'h33333333, 1'b0, 4'hf);
        send(32'h44444444, 1'b0, 4'hf);
        send(32'h55555555, 1'b0, 4'hf);
        send(32'h66666666, 1'b0, 4'hf);
        @(negedge clk);
        inValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (rxEmpty !== 1'b1 || level !== 3'd0 || rxData !== 128'h0) begin
            failures++;
            $display("FAIL rstmid_state got empty=%b level=%0d data=%h exp 1/0/0", rxEmpty, level, rxData);
        end
        checks++;
        if (inReady !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", inReady); end
        rst = 1'b0;
        send_block(128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd, 4, 1'b0, 4'hf);
        idle();
        checks++;
        if (level !== 3'd1) begin failures++; $display("FAIL rstmid_level got=%0d exp=1", level); end
        pop_block(d, e);
        checks++;
        if (d !== sbq[0]) begin failures++; $display("FAIL rstmid_data got=%h exp=%h", d, sbq[0]); end
        void'(sbq.pop_front());
        @(negedge clk);
        checks++;
        if (rxEmpty !== 1'b1) begin failures++; $display("FAIL rstmid_after got=%b exp=1", rxEmpty); end
    endtask

    task automatic test_simul_commit_pop();
        logic [127:0] d;
        logic [127:0] head;
        logic [127:0] w;
        logic e;
        send_block({$urandom, $urandom, $urandom, $urandom}, 4, 1'b0, 4'hf);
        send_block({$urandom, $urandom, $urandom, $urandom}, 4, 1'b0, 4'hf);
        idle();
        checks++;
        if (level !== 3'd2) begin failures++; $display("FAIL sim_pre_level got=%0d exp=2", level); end
        w = {$urandom, $urandom, $urandom, $urandom};
        sbq.push_back(w);
        for (int k = 0; k < 3; k++) send(w[127-32*k -: 32], 1'b0, 4'hf);
        @(negedge clk);
        inValid = 1'b1; inData = w[31:0]; inLast = 1'b0;
        rxPop = 1'b1;
        head = rxData;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0; rxPop = 1'b0;
        checks++;
        if (level !== 3'd2) begin failures++; $display("FAIL sim_level got=%0d exp=2", level); end
        checks++;
        if (head !== sbq[0]) begin failures++; $display("FAIL sim_head got=%h exp=%h", head, sbq[0]); end
        void'(sbq.pop_front());
        checks++;
        if (rxData !== sbq[0]) begin failures++; $display("FAIL sim_next got=%h exp=%h", rxData, sbq[0]); end
        for (int k = 0; k < 20 && sbq.size() > 0; k++) begin
            pop_block(d, e);
            checks++;
            if (d !== sbq[0]) begin failures++; $display("FAIL sim_drain%0d got=%h exp=%h", k, d, sbq[0]); end
            void'(sbq.pop_front());
        end
        checks++;
        if (d !== w) begin failures++; $display("FAIL sim_tail got=%h exp=%h", d, w); end
    endtask

    initial begin
        rst = 1'b1; inValid = 1'b0; inData = '0; inKeep = '0; inLast = 1'b0; rxPop = 1'b0;
        test_reset();
        test_full_block();
        test_partial_keep();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_simul_commit_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
